// File: rtl/argmax_stream_pkg.sv
// Shared types and constants for the angle-estimation argmax path.
// Widths here are the defaults; blocks stay width-generic through parameters.
package data_type;

    localparam int LAMBDA_W = 14;
    localparam int ANG_W    = 11;
    localparam int EPS_W    = 22;
    localparam int PI_W     = 8;

    // 1/(2*pi) as unsigned Q0.8
    localparam logic [PI_W-1:0] INV_TWO_PI_RAW = 8'd40;

    typedef logic signed [LAMBDA_W-1:0] lambda_t;
    typedef logic signed [ANG_W-1:0]    ang_t;
    typedef logic signed [EPS_W-1:0]    eps_t;
    typedef logic [7:0]                 theta_t;

    localparam lambda_t MIN_LAMBDA = {1'b1, {(LAMBDA_W-1){1'b0}}};

    typedef enum logic {
        ST_SKIP,
        ST_ACC
    } state_t;

endpackage

// File: rtl/argmax_stream_eps_scale.sv
// Combinational angle -> eps scaling: angle * (1/2pi), re-aligned to 20 fractional bits.
module argmax_eps_scale #(
    parameter int ANG_W = 11,
    parameter int EPS_W = 22
) (
    input  logic signed [ANG_W-1:0] angle,
    output logic signed [EPS_W-1:0] eps
);
    import data_type::*;

    localparam int PROD_W = ANG_W + PI_W + 1;
    localparam int SH_W   = PROD_W + 4;

    logic signed [PROD_W-1:0] product;
    logic signed [SH_W-1:0]   shifted;

    // Product carries 16 fractional bits; the shift brings it to 20.
    assign product = PROD_W'(angle) * PROD_W'($signed({1'b0, INV_TWO_PI_RAW}));
    assign shifted = SH_W'(product) <<< 4;
    assign eps     = EPS_W'(shifted);

endmodule

// File: rtl/argmax_stream.sv
// Streaming block argmax: peak lambda position, eps at the peak and peak-to-runner-up margin.
module argmax_stream #(
    parameter int BLOCK_LEN  = 256,
    parameter int START_SKIP = 280,
    parameter bit TIE_LAST   = 1'b1,
    parameter int LAMBDA_W   = data_type::LAMBDA_W,
    parameter int ANG_W      = data_type::ANG_W,
    parameter int EPS_W      = data_type::EPS_W,
    parameter int THETA_W    = $clog2(BLOCK_LEN)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic signed [LAMBDA_W-1:0] lambda_in,
    input  logic signed [ANG_W-1:0]    angle_in,
    output logic                       out_valid,
    output logic [THETA_W-1:0]         theta_out,
    output logic signed [EPS_W-1:0]    eps_out,
    output logic signed [LAMBDA_W-1:0] peak_out,
    output logic [LAMBDA_W-1:0]        margin_out,
    output logic                       drop_out
);
    import data_type::*;

    localparam int SKIP_W = (START_SKIP > 0) ? $clog2(START_SKIP + 1) : 1;
    localparam logic [SKIP_W-1:0]         SKIP_INIT = SKIP_W'(START_SKIP);
    localparam logic [THETA_W-1:0]        LAST_POS  = THETA_W'(BLOCK_LEN - 1);
    localparam logic signed [LAMBDA_W-1:0] MIN_L    = {1'b1, {(LAMBDA_W-1){1'b0}}};
    localparam state_t RESET_STATE = (START_SKIP == 0) ? ST_ACC : ST_SKIP;

    state_t                      state_q, state_d;
    logic [SKIP_W-1:0]           skip_q, skip_d;
    logic [THETA_W-1:0]          pos_q, pos_d;
    logic signed [LAMBDA_W-1:0]  max_q, max_d;
    logic signed [LAMBDA_W-1:0]  second_q, second_d;
    logic [THETA_W-1:0]          max_pos_q, max_pos_d;
    logic signed [ANG_W-1:0]     max_ang_q, max_ang_d;
    logic                        out_valid_q, out_valid_d;
    logic                        drop_q, drop_d;
    logic [THETA_W-1:0]          theta_q, theta_d;
    logic signed [EPS_W-1:0]     eps_q, eps_d;
    logic signed [LAMBDA_W-1:0]  peak_q, peak_d;
    logic [LAMBDA_W-1:0]         margin_q, margin_d;

    logic                        take;
    logic                        win;
    logic [THETA_W-1:0]          cur_pos;
    logic [LAMBDA_W:0]           diff;
    logic signed [EPS_W-1:0]     eps_next;

    argmax_eps_scale #(
        .ANG_W (ANG_W),
        .EPS_W (EPS_W)
    ) u_eps_scale (
        .angle (max_ang_d),
        .eps   (eps_next)
    );

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        pos_d       = pos_q;
        max_d       = max_q;
        second_d    = second_q;
        max_pos_d   = max_pos_q;
        max_ang_d   = max_ang_q;
        out_valid_d = 1'b0;
        drop_d      = 1'b0;
        theta_d     = theta_q;
        peak_d      = peak_q;
        margin_d    = margin_q;
        take        = 1'b0;
        cur_pos     = pos_q;
        diff        = '0;
        win         = TIE_LAST ? (lambda_in >= max_q) : (lambda_in > max_q);

        // A start-of-block marker always restarts at position 0, whether skipping or mid-block.
        if (in_valid) begin
            if (state_q == ST_SKIP) begin
                if (in_sof) begin
                    take    = 1'b1;
                    cur_pos = '0;
                    state_d = ST_ACC;
                end else if (skip_q == SKIP_W'(1)) begin
                    state_d = ST_ACC;
                    pos_d   = '0;
                end else begin
                    skip_d = skip_q - 1'b1;
                end
            end else begin
                take = 1'b1;
                if (in_sof && pos_q != '0) begin
                    drop_d  = 1'b1;
                    cur_pos = '0;
                end
            end
        end

        if (take) begin
            if (cur_pos == '0) begin
                max_d     = lambda_in;
                second_d  = MIN_L;
                max_pos_d = '0;
                max_ang_d = angle_in;
            end else if (win) begin
                second_d  = max_q;
                max_d     = lambda_in;
                max_pos_d = cur_pos;
                max_ang_d = angle_in;
            end else if (lambda_in > second_q) begin
                second_d = lambda_in;
            end

            // Margin is never negative, so the extra bit only flags overflow.
            diff = {max_d[LAMBDA_W-1], max_d} - {second_d[LAMBDA_W-1], second_d};
            if (cur_pos == LAST_POS) begin
                out_valid_d = 1'b1;
                theta_d     = max_pos_d;
                peak_d      = max_d;
                margin_d    = diff[LAMBDA_W] ? '1 : diff[LAMBDA_W-1:0];
                pos_d       = '0;
            end else begin
                pos_d = cur_pos + 1'b1;
            end
        end
    end

    assign eps_d = out_valid_d ? eps_next : eps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            skip_q      <= SKIP_INIT;
            pos_q       <= '0;
            max_q       <= MIN_L;
            second_q    <= MIN_L;
            max_pos_q   <= '0;
            max_ang_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            theta_q     <= '0;
            eps_q       <= '0;
            peak_q      <= MIN_L;
            margin_q    <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            pos_q       <= pos_d;
            max_q       <= max_d;
            second_q    <= second_d;
            max_pos_q   <= max_pos_d;
            max_ang_q   <= max_ang_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            theta_q     <= theta_d;
            eps_q       <= eps_d;
            peak_q      <= peak_d;
            margin_q    <= margin_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign drop_out   = drop_q;
    assign theta_out  = theta_q;
    assign eps_out    = eps_q;
    assign peak_out   = peak_q;
    assign margin_out = margin_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: directed blocks, a block-level reference model and literal pins.
module tb_argmax_stream;

    localparam int BLOCK_LEN  = 256;
    localparam int START_SKIP = 280;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [13:0] lambda_in = '0;
    logic [10:0] angle_in = '0;

    logic        ov_l, dr_l, ov_f, dr_f;
    logic [7:0]  th_l, th_f;
    logic [21:0] ep_l, ep_f;
    logic [13:0] pk_l, pk_f, mg_l, mg_f;

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int dcount = 0;

    always #5 clk = ~clk;

    argmax_stream #(.BLOCK_LEN(BLOCK_LEN), .START_SKIP(START_SKIP), .TIE_LAST(1'b1)) dut_last (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .lambda_in(lambda_in), .angle_in(angle_in),
        .out_valid(ov_l), .theta_out(th_l), .eps_out(ep_l), .peak_out(pk_l),
        .margin_out(mg_l), .drop_out(dr_l)
    );

    argmax_stream #(.BLOCK_LEN(BLOCK_LEN), .START_SKIP(START_SKIP), .TIE_LAST(1'b0)) dut_first (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .lambda_in(lambda_in), .angle_in(angle_in),
        .out_valid(ov_f), .theta_out(th_f), .eps_out(ep_f), .peak_out(pk_f),
        .margin_out(mg_f), .drop_out(dr_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect each block's samples, then score it as a whole.
    int  blk_lam[$];
    int  blk_ang[$];
    bit  skipping = 1'b1;
    int  skip_left = START_SKIP;
    logic        exp_valid = 1'b0;
    logic        exp_drop = 1'b0;
    logic [7:0]  exp_th_l = '0, exp_th_f = '0;
    logic [21:0] exp_ep_l = '0, exp_ep_f = '0;
    logic [13:0] exp_pk = 14'h2000;
    logic [13:0] exp_mg_l = '0, exp_mg_f = '0;

    function automatic void score(input bit tie_last, output logic [7:0] th,
                                  output logic [21:0] ep, output logic [13:0] mg);
        int pk = -100000;
        int ru = -100000;
        int idx = 0;
        bit found = 1'b0;
        int m;
        for (int j = 0; j < blk_lam.size(); j++)
            if (blk_lam[j] > pk) pk = blk_lam[j];
        for (int j = 0; j < blk_lam.size(); j++) begin
            if (blk_lam[j] == pk && (tie_last || !found)) begin
                idx = j;
                found = 1'b1;
            end
        end
        for (int j = 0; j < blk_lam.size(); j++)
            if (j != idx && blk_lam[j] > ru) ru = blk_lam[j];
        m = pk - ru;
        if (m > 16383) m = 16383;
        th = 8'(idx);
        ep = 22'(blk_ang[idx] * 640);
        mg = 14'(m);
    endfunction

    function automatic int block_peak();
        int pk = -100000;
        for (int j = 0; j < blk_lam.size(); j++)
            if (blk_lam[j] > pk) pk = blk_lam[j];
        return pk;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            skipping  = (START_SKIP != 0);
            skip_left = START_SKIP;
            blk_lam.delete();
            blk_ang.delete();
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
            exp_th_l  = '0;
            exp_th_f  = '0;
            exp_ep_l  = '0;
            exp_ep_f  = '0;
            exp_pk    = 14'h2000;
            exp_mg_l  = '0;
            exp_mg_f  = '0;
        end else begin
            exp_valid = 1'b0;
            exp_drop  = 1'b0;
            if (in_valid) begin
                if (skipping && !in_sof) begin
                    skip_left--;
                    if (skip_left == 0) skipping = 1'b0;
                end else begin
                    if (skipping) begin
                        skipping = 1'b0;
                    end else if (in_sof && blk_lam.size() != 0) begin
                        exp_drop = 1'b1;
                        blk_lam.delete();
                        blk_ang.delete();
                    end
                    blk_lam.push_back(int'($signed(lambda_in)));
                    blk_ang.push_back(int'($signed(angle_in)));
                    if (blk_lam.size() == BLOCK_LEN) begin
                        exp_valid = 1'b1;
                        exp_pk = 14'(block_peak());
                        score(1'b1, exp_th_l, exp_ep_l, exp_mg_l);
                        score(1'b0, exp_th_f, exp_ep_f, exp_mg_f);
                        blk_lam.delete();
                        blk_ang.delete();
                    end
                end
            end
        end
    end

    // Outputs are compared against the model on every falling edge.
    always @(negedge clk) begin
        check("valid_l", 32'(ov_l), 32'(exp_valid));
        check("valid_f", 32'(ov_f), 32'(exp_valid));
        check("drop_l", 32'(dr_l), 32'(exp_drop));
        check("drop_f", 32'(dr_f), 32'(exp_drop));
        check("theta_l", 32'(th_l), 32'(exp_th_l));
        check("theta_f", 32'(th_f), 32'(exp_th_f));
        check("eps_l", 32'(ep_l), 32'(exp_ep_l));
        check("eps_f", 32'(ep_f), 32'(exp_ep_f));
        check("peak_l", 32'(pk_l), 32'(exp_pk));
        check("peak_f", 32'(pk_f), 32'(exp_pk));
        check("margin_l", 32'(mg_l), 32'(exp_mg_l));
        check("margin_f", 32'(mg_f), 32'(exp_mg_f));
        if (ov_l === 1'b1) vcount++;
        if (dr_l === 1'b1) dcount++;
    end

    task automatic apply_stimulus(input bit v, input bit s, input int lam, input int ang);
        @(negedge clk);
        in_valid  = v;
        in_sof    = s;
        lambda_in = 14'(lam);
        angle_in  = 11'(ang);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, 0, 0);
    endtask

    task automatic check_output(input string nm, input logic [7:0] tl, input logic [7:0] tf,
                                input logic [21:0] el, input logic [21:0] ef, input logic [13:0] pk,
                                input logic [13:0] ml, input logic [13:0] mf);
        check({nm, "_theta_l"}, 32'(th_l), 32'(tl));
        check({nm, "_theta_f"}, 32'(th_f), 32'(tf));
        check({nm, "_eps_l"}, 32'(ep_l), 32'(el));
        check({nm, "_eps_f"}, 32'(ep_f), 32'(ef));
        check({nm, "_peak_l"}, 32'(pk_l), 32'(pk));
        check({nm, "_peak_f"}, 32'(pk_f), 32'(pk));
        check({nm, "_margin_l"}, 32'(mg_l), 32'(ml));
        check({nm, "_margin_f"}, 32'(mg_f), 32'(mf));
    endtask

    initial begin
        int vb, db;
        #1 rst = 1'b1;
        #11;
        check("rst_valid", 32'(ov_l), 32'd0);
        check("rst_drop", 32'(dr_l), 32'd0);
        check_output("rst", 8'h00, 8'h00, 22'h0, 22'h0, 14'h2000, 14'h0, 14'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < START_SKIP; i++) apply_stimulus(1'b1, 1'b0, 4000, 7);

        for (int i = 0; i < BLOCK_LEN; i++) apply_stimulus(1'b1, 1'b0, i, i);

        // Next block starts back-to-back; the ramp results must hold meanwhile.
        for (int i = 0; i < BLOCK_LEN; i++) begin
            apply_stimulus(1'b1, 1'b0, (i == 37) ? 100 : 0, (i == 37) ? 256 : 0);
            if (i == 3)
                check_output("ramp", 8'hFF, 8'hFF, 22'h27D80, 22'h27D80, 14'h0FF, 14'h001, 14'h001);
        end
        idle(2);
        check_output("single", 8'h25, 8'h25, 22'h28000, 22'h28000, 14'h064, 14'h064, 14'h064);

        for (int i = 0; i < BLOCK_LEN; i++)
            apply_stimulus(1'b1, 1'b0, (i == 10 || i == 200) ? 50 : 0,
                           (i == 10) ? 1 : ((i == 200) ? 2 : 0));
        idle(2);
        check_output("tie", 8'hC8, 8'h0A, 22'h500, 22'h280, 14'h032, 14'h000, 14'h000);

        vb = vcount;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            apply_stimulus(1'b1, 1'b0, (i == 3) ? 300 : -20, (i == 3) ? -1024 : 5);
            idle(2);
        end
        idle(2);
        check("gap_pulses", 32'(vcount - vb), 32'd1);
        check_output("gap", 8'h03, 8'h03, 22'h360000, 22'h360000, 14'h12C, 14'h140, 14'h140);

        vb = vcount;
        db = dcount;
        for (int i = 0; i < 120; i++) apply_stimulus(1'b1, i == 0, (i == 50) ? 1000 : 0, 0);
        for (int i = 0; i < BLOCK_LEN; i++)
            apply_stimulus(1'b1, i == 0, (i == 5) ? 500 : (i % 7), i);
        idle(2);
        check("sof_drops", 32'(dcount - db), 32'd1);
        check("sof_pulses", 32'(vcount - vb), 32'd1);
        check_output("sof", 8'h05, 8'h05, 22'hC80, 22'hC80, 14'h1F4, 14'h1EE, 14'h1EE);

        for (int i = 0; i < BLOCK_LEN; i++)
            apply_stimulus(1'b1, 1'b0, (i == 0) ? 8191 : -8192, (i == 0) ? 1023 : 0);
        idle(2);
        check_output("extreme", 8'h00, 8'h00, 22'h9FD80, 22'h9FD80, 14'h1FFF, 14'h3FFF, 14'h3FFF);

        for (int i = 0; i < 50; i++) apply_stimulus(1'b1, 1'b0, 9, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(ov_l), 32'd0);
        check_output("midrst", 8'h00, 8'h00, 22'h0, 22'h0, 14'h2000, 14'h0, 14'h0);
        idle(2);
        rst = 1'b0;

        vb = vcount;
        db = dcount;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 4000, 7);
        for (int i = 0; i < BLOCK_LEN; i++) apply_stimulus(1'b1, i == 0, 255 - i, -3);
        idle(3);
        check("abort_drops", 32'(dcount - db), 32'd0);
        check("abort_pulses", 32'(vcount - vb), 32'd1);
        check_output("abort", 8'h00, 8'h00, 22'h3FF880, 22'h3FF880, 14'h0FF, 14'h001, 14'h001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
# argmax_stream

Parametrised streaming block-argmax for the angle-estimation path. It consumes one (lambda, angle) sample per accepted beat and tracks the peak lambda over each block of BLOCK_LEN samples. At block end it emits the peak position (theta), the normalised angle at the peak (eps = angle/2π) and the peak-to-runner-up margin. It is the handshaked, re-synchronisable, width-generic successor of the fixed 256-point argmax and sits between the lambda/angle generator and the frequency/timing correction stage.

## Interface
- BLOCK_LEN, 256: samples per block; power of two not required, ≥2
- START_SKIP, 280: valid samples discarded after reset before the first block
- TIE_LAST, 1: 1 = later sample wins ties (>=); 0 = first sample wins (>)
- LAMBDA_W, 14: lambda width, signed Q6.8
- ANG_W, 11: angle width, signed Q3.8 (ANG_F = 8)
- EPS_W, 22: eps width, signed, 20 fractional bits
- THETA_W, $clog2(BLOCK_LEN): theta width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  sample qualifier
- in_sof  in  1  start-of-block marker, sampled only with in_valid
- lambda_in  in  LAMBDA_W  metric sample, signed
- angle_in  in  ANG_W  angle sample, signed
- out_valid  out  1  one-cycle pulse per completed block
- theta_out  out  THETA_W  position of peak within block (0..BLOCK_LEN-1)
- eps_out  out  EPS_W  angle at peak × INV_TWO_PI
- peak_out  out  LAMBDA_W  peak lambda
- margin_out  out  LAMBDA_W  peak − runner-up, unsigned, saturated to all-ones
- drop_out  out  1  one-cycle pulse: partial block discarded by in_sof

## Operation
- States: SKIP, ACC. Reset → SKIP with skip counter = START_SKIP (START_SKIP = 0 → ACC directly).
- SKIP: each in_valid decrements counter; at the beat that brings it to 0, go to ACC with pos = 0. in_valid && in_sof in SKIP: abort skip, treat that sample as pos 0 in ACC, no drop_out.
- ACC, pos = 0 beat: max = lambda, max_pos = 0, max_ang = angle, second = MIN_LAMBDA (most negative code).
- ACC, pos > 0 beat: win = TIE_LAST ? (lambda >= max) : (lambda > max). If win: second = max, max = lambda, max_pos = pos, max_ang = angle. Else second = max(second, lambda).
- pos = BLOCK_LEN-1 beat: latch outputs from post-update values, pulse out_valid, pos → 0.
- in_valid && in_sof while pos ≠ 0: discard partial block, pulse drop_out, sample becomes pos 0 of new block.
- in_valid low: no state change.
- eps: product = max_ang × 40 (INV_TWO_PI, unsigned Q0.8 = 0.15625), ANG_W+9 bits signed, 16 fractional bits; shift left 4; truncate to EPS_W.
- margin: (max − second) computed in LAMBDA_W+1 bits; values ≥ 2^LAMBDA_W saturate; second = MIN_LAMBDA with one distinct sample is legal.

## Timing
- Reset values: out_valid 0, drop_out 0, theta_out 0, eps_out 0, peak_out MIN_LAMBDA, margin_out 0, state SKIP.
- Latency: out_valid and outputs registered one cycle after the last beat of a block is accepted.
- Output data holds until the next out_valid; never changes between pulses.
- No backpressure; in_valid may be continuous; a new block's pos 0 may coincide with the previous block's out_valid cycle.
- Reset mid-block: all state discarded asynchronously; no output for that block.

## Structure
- Shared package data_type: lambda_t, ang_t, theta_t, eps_t, LAMBDA_W, ANG_W, EPS_W, PI_W, INV_TWO_PI_RAW, MIN_LAMBDA.
- Sub-module argmax_eps_scale: combinational angle → eps multiplier/shift, reused by other estimators.

## Test plan
- Reset, START_SKIP=280, BLOCK_LEN=256, ramp lambda 0..255 after skip → out_valid 1 cycle after beat 255, theta 255, peak 255, margin 1.
- Single peak lambda=100 at pos 37, angle=0x100 (1.0), rest 0 → theta 37, eps 0x28000 (0.15625), margin 100.
- Ties: lambda=50 at pos 10 and 200, rest 0 → TIE_LAST=1: theta 200, margin 0; TIE_LAST=0: theta 10, margin 0.
- Gapped in_valid (1 of 3 cycles) over full block → same outputs as continuous stream; out_valid exactly once.
- in_sof at pos 120 → drop_out pulse, no out_valid, next out_valid after 256 further beats with theta relative to sof.
- angle=−1024 (−4.0) at peak → eps = −0x0A0000 (−0.625); async rst asserted mid-block → outputs at reset values immediately.
